// File: rtl/cpu_mc_pkg.sv
// cpu_mc shared definitions: opcodes, FSM states, ALU ops.
// Imported by the core, its ALU and the bus interface users.
package cpu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQZ = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JAL  = 4'hC;
  localparam logic [3:0] OP_JR   = 4'hD;
  localparam logic [3:0] OP_ILL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_PASS_B
  } alu_op_t;

endpackage

// File: rtl/cpu_mc_if.sv
// cpu_mc memory bus: fetch and data req/ack channels.
// master = core side, slave = memory / harness side.
interface cpu_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 16
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_ack;
  logic [15:0]           imem_rdata;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we,
    output dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we,
    input  dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu_mc_alu.sv
// cpu_mc combinational ALU.
// Ports: op, a, b in; y out (DATA_WIDTH wide).
module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_AND:    y = a & b;
      ALU_OR:     y = a | b;
      ALU_XOR:    y = a ^ b;
      ALU_SLT:    y = {{(DATA_WIDTH-1){1'b0}}, lt};
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc multi-cycle 16-bit-ISA core with req/ack memories.
// Ports: clk, reset (async low), bus (master), debug_*, halted, illegal, instret.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int                  DATA_WIDTH = 16,
  parameter int                  PC_WIDTH   = 16,
  parameter int                  CNT_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_mc_if.master              bus,
  input  logic [3:0]            debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data,
  output logic                  halted,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  instret
);

  state_t state, state_d;

  logic [PC_WIDTH-1:0]   pc, pc_inc;
  logic [PC_WIDTH-1:0]   npc_c, npc_q, pc_next;
  logic [15:0]           ir;
  logic [3:0]            opc, rd, rs, rt;
  logic [DATA_WIDTH-1:0] regs [16];
  logic [DATA_WIDTH-1:0] a_q, b_q, d_q, imm_q, res_q;
  logic [DATA_WIDTH-1:0] sext8, sext4;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_y;
  alu_op_t               alu_op;
  logic                  ill_q, retire, wr_en;

  assign opc    = ir[15:12];
  assign rd     = ir[11:8];
  assign rs     = ir[7:4];
  assign rt     = ir[3:0];
  assign sext8  = {{(DATA_WIDTH-8){ir[7]}}, ir[7:0]};
  assign sext4  = {{(DATA_WIDTH-4){ir[3]}}, ir[3:0]};
  assign pc_inc = pc + 1'b1;

  assign debug_data = (debug_addr == 4'd0) ? '0 : regs[debug_addr];
  assign halted     = (state == ST_HALT);
  assign illegal    = ill_q;

  // Requests are gated by reset so nothing is asked for while held.
  assign bus.imem_req   = reset && (state == ST_FETCH);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = reset && (state == ST_MEM);
  assign bus.dmem_we    = (opc == OP_ST);
  assign bus.dmem_addr  = res_q;
  assign bus.dmem_wdata = d_q;

  cpu_mc_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = a_q;
    alu_b  = b_q;
    unique case (1'b1)
      (opc == OP_SUB): alu_op = ALU_SUB;
      (opc == OP_AND): alu_op = ALU_AND;
      (opc == OP_OR):  alu_op = ALU_OR;
      (opc == OP_XOR): alu_op = ALU_XOR;
      (opc == OP_SLT): alu_op = ALU_SLT;
      (opc == OP_LDI): begin
        alu_op = ALU_PASS_B;
        alu_b  = imm_q;
      end
      (opc == OP_ADDI): begin
        alu_a = d_q;
        alu_b = imm_q;
      end
      (opc == OP_LD),
      (opc == OP_ST): alu_b = imm_q;
      (opc == OP_JAL): begin
        alu_op = ALU_PASS_B;
        alu_b  = '0;
        alu_b[PC_WIDTH-1:0] = pc_inc;
      end
      default: ;
    endcase
  end

  always_comb begin
    npc_c = pc_inc;
    unique case (1'b1)
      (opc == OP_BEQZ):
        if (d_q == '0) npc_c = pc_inc + imm_q[PC_WIDTH-1:0];
      (opc == OP_JMP): npc_c = PC_WIDTH'(ir[11:0]);
      (opc == OP_JAL): npc_c = PC_WIDTH'(ir[7:0]);
      (opc == OP_JR):  npc_c = d_q[PC_WIDTH-1:0];
      default: ;
    endcase
  end

  // Control flow retires straight out of EXEC, so it uses the live target.
  assign pc_next = (state == ST_EXEC) ? npc_c : npc_q;

  always_comb begin
    state_d = state;
    retire  = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      ST_FETCH:
        if (bus.imem_ack) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        unique case (1'b1)
          (opc == OP_LD),
          (opc == OP_ST): state_d = ST_MEM;
          (opc == OP_BEQZ),
          (opc == OP_JMP),
          (opc == OP_JR): begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          (opc == OP_HALT): begin
            state_d = ST_HALT;
            retire  = 1'b1;
          end
          (opc == OP_ILL): state_d = ST_HALT;
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM:
        if (bus.dmem_ack) begin
          state_d = (opc == OP_LD) ? ST_WB : ST_FETCH;
          retire  = (opc == OP_ST);
        end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
        wr_en   = (rd != 4'd0);
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      npc_q   <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
      instret <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= state_d;
      if (state == ST_FETCH && bus.imem_ack)
        ir <= bus.imem_rdata;
      if (state == ST_DECODE) begin
        a_q   <= regs[rs];
        b_q   <= regs[rt];
        d_q   <= regs[rd];
        imm_q <= (opc == OP_LD || opc == OP_ST) ? sext4 : sext8;
      end
      if (state == ST_EXEC) begin
        res_q <= alu_y;
        npc_q <= npc_c;
        if (opc == OP_ILL) ill_q <= 1'b1;
      end
      if (state == ST_MEM && bus.dmem_ack && opc == OP_LD)
        res_q <= bus.dmem_rdata;
      if (wr_en) regs[rd] <= res_q;
      if (retire) begin
        instret <= instret + 1'b1;
        if (opc != OP_HALT) pc <= pc_next;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// cpu_mc bench: programs, req/ack memory models, scoreboards.
// Covers 16-bit core plus a 32-bit instance for the reset case.
module tb_cpu_mc;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } dacc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst32_n;
  logic [3:0]  dbg_a, dbg32_a;
  logic [15:0] dbg_d;
  logic [31:0] dbg32_d;
  logic        halted, illegal, h32, il32;
  logic [31:0] instret, ir32;

  cpu_mc_if #(.DATA_WIDTH(16), .PC_WIDTH(16)) bus ();
  cpu_mc_if #(.DATA_WIDTH(32), .PC_WIDTH(16)) b32 ();

  cpu_mc #(.DATA_WIDTH(16), .PC_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .bus        (bus),
    .debug_addr (dbg_a),
    .debug_data (dbg_d),
    .halted     (halted),
    .illegal    (illegal),
    .instret    (instret)
  );

  cpu_mc #(.DATA_WIDTH(32), .PC_WIDTH(16)) dut32 (
    .clk        (clk),
    .reset      (rst32_n),
    .bus        (b32),
    .debug_addr (dbg32_a),
    .debug_data (dbg32_d),
    .halted     (h32),
    .illegal    (il32),
    .instret    (ir32)
  );

  logic [15:0] imem [65536];
  logic [15:0] dmem [256];
  logic [15:0] prog32 [4];
  logic [15:0] fq [$];
  dacc_t       dq [$];
  int          i_wait, d_wait, icnt, dcnt, n_st32;
  bit          force_dack, d32_ok, d32_late;
  logic [15:0] ia_hold, da_hold;
  int          n_chk, n_err;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 16-bit memories: configurable wait, scoreboards popped on ack.
  always @(negedge clk) begin : resp
    dacc_t e;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    if (bus.imem_req) begin
      if (icnt > 0) check("imem_addr_stable", bus.imem_addr, ia_hold);
      ia_hold = bus.imem_addr;
      if (icnt >= i_wait) begin
        icnt = 0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = imem[bus.imem_addr];
        if (fq.size() == 0) check("fetch_extra", 1, 0);
        else check("fetch_addr", bus.imem_addr, fq.pop_front());
      end else icnt++;
    end else icnt = 0;
    if (bus.dmem_req) begin
      if (dcnt > 0) check("dmem_addr_stable", bus.dmem_addr, da_hold);
      da_hold = bus.dmem_addr;
      if (dcnt >= d_wait) begin
        dcnt = 0;
        bus.dmem_ack = 1'b1;
        if (bus.dmem_we) dmem[bus.dmem_addr[7:0]] = bus.dmem_wdata;
        else bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];
        if (dq.size() == 0) check("dmem_extra", 1, 0);
        else begin
          e = dq.pop_front();
          check("dmem_we", bus.dmem_we, e.we);
          check("dmem_addr", bus.dmem_addr, e.addr);
          if (e.we) check("dmem_wdata", bus.dmem_wdata, e.wdata);
        end
      end else dcnt++;
    end else dcnt = 0;
    if (force_dack) bus.dmem_ack = 1'b1;
  end

  always @(negedge clk) begin
    b32.imem_ack   = b32.imem_req;
    b32.imem_rdata = prog32[b32.imem_addr[1:0]];
    b32.dmem_ack   = (b32.dmem_req & d32_ok) | d32_late;
    b32.dmem_rdata = '0;
    if (b32.dmem_req && b32.dmem_ack && b32.dmem_we) begin
      n_st32++;
      check("st32_addr", b32.dmem_addr, 32'h3);
      check("st32_data", b32.dmem_wdata, 32'hFFFF_FFFE);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) imem[i] = 16'hF000;
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0;
  endtask

  task automatic push_fetch(input int a);
    fq.push_back(16'(a));
  endtask

  task automatic push_d(input logic we, input int a, input int w);
    dacc_t e;
    e.we = we;
    e.addr = 16'(a);
    e.wdata = 16'(w);
    dq.push_back(e);
  endtask

  // Release is placed just after a rising edge so the first fetch
  // is acknowledged before the first counted edge.
  task automatic start_run();
    rst_n = 1'b0;
    force_dack = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 500) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
    end
    check("halted", halted, 1);
  endtask

  task automatic reg_chk(string tag, input logic [3:0] r, input logic [15:0] e);
    dbg_a = r;
    #1 check(tag, dbg_d, e);
  endtask

  int tr4 [11] = '{0, 3, 'h40, 'h41, 4, 5, 6, 'hFFFF, 0, 1, 'h20};
  int cyc, n_req;

  initial begin
    n_chk = 0; n_err = 0; n_st32 = 0;
    icnt = 0; dcnt = 0; i_wait = 0; d_wait = 0;
    force_dack = 0; d32_ok = 0; d32_late = 0;
    bus.imem_ack = 0; bus.dmem_ack = 0;
    bus.imem_rdata = '0; bus.dmem_rdata = '0;
    b32.imem_ack = 0; b32.dmem_ack = 0;
    b32.imem_rdata = '0; b32.dmem_rdata = '0;
    dbg_a = 0; dbg32_a = 0;
    rst_n = 1'b0; rst32_n = 1'b0;
    prog32[0] = 16'h61FE; prog32[1] = 16'h9103;
    prog32[2] = 16'hF000; prog32[3] = 16'hF000;
    #12;
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_instret", instret, 0);

    // zero-wait, then 3-cycle fetch waits
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      imem[0] = 16'h6105; imem[1] = 16'h62FD;
      imem[2] = 16'h0312; imem[3] = 16'hF000;
      for (int i = 0; i < 4; i++) push_fetch(i);
      i_wait = (pass == 0) ? 0 : 3;
      start_run();
      run_halt(cyc);
      check("t1_cycles", cyc, (pass == 0) ? 15 : 27);
      reg_chk("t1_r1", 1, 16'h0005);
      reg_chk("t1_r2", 2, 16'hFFFD);
      reg_chk("t1_r3", 3, 16'h0002);
      check("t1_instret", instret, 4);
      check("t1_pc", bus.imem_addr, 3);
      check("t1_req_low", bus.imem_req, 0);
      check("t1_illegal", illegal, 0);
      check("t1_fq_empty", fq.size(), 0);
    end
    i_wait = 0;

    // loads and stores with 2-cycle data waits
    clear_mem();
    dmem[8'h20] = 16'hBEEF; dmem[8'h0F] = 16'h1234;
    imem[0] = 16'h6620; imem[1] = 16'h6410; imem[2] = 16'h8160;
    imem[3] = 16'h9142; imem[4] = 16'h8542; imem[5] = 16'h804F;
    imem[6] = 16'hF000;
    for (int i = 0; i < 7; i++) push_fetch(i);
    push_d(0, 'h20, 0); push_d(1, 'h12, 'hBEEF);
    push_d(0, 'h12, 0); push_d(0, 'h0F, 0);
    d_wait = 2;
    start_run();
    run_halt(cyc);
    check("t3_cycles", cyc, 38);
    reg_chk("t3_r1", 1, 16'hBEEF);
    reg_chk("t3_r5", 5, 16'hBEEF);
    reg_chk("t3_r4", 4, 16'h0010);
    reg_chk("t3_r0", 0, 16'h0000);
    check("t3_mem12", dmem[8'h12], 16'hBEEF);
    check("t3_instret", instret, 7);
    check("t3_dq_empty", dq.size(), 0);
    d_wait = 0;

    // branches, JAL/JR, PC wrap
    clear_mem();
    imem[0] = 16'hA802; imem[1] = 16'hB020; imem[2] = 16'h6102;
    imem[3] = 16'hC740; imem[4] = 16'hA205; imem[5] = 16'h63FF;
    imem[6] = 16'hD300; imem['h20] = 16'hF000;
    imem['h40] = 16'h6209; imem['h41] = 16'hD700;
    imem['hFFFF] = 16'h6801;
    foreach (tr4[i]) push_fetch(tr4[i]);
    start_run();
    run_halt(cyc);
    check("t4_cycles", cyc, 37);
    reg_chk("t4_r7", 7, 16'h0004);
    reg_chk("t4_r2", 2, 16'h0009);
    reg_chk("t4_r3", 3, 16'hFFFF);
    reg_chk("t4_r8", 8, 16'h0001);
    reg_chk("t4_r1", 1, 16'h0000);
    check("t4_pc", bus.imem_addr, 'h20);
    check("t4_instret", instret, 11);
    check("t4_fq_empty", fq.size(), 0);

    // illegal opcode trap
    clear_mem();
    imem[0] = 16'h6007; imem[1] = 16'hB008; imem[8] = 16'hE000;
    push_fetch(0); push_fetch(1); push_fetch(8);
    start_run();
    run_halt(cyc);
    check("t5_cycles", cyc, 10);
    check("t5_illegal", illegal, 1);
    check("t5_pc", bus.imem_addr, 8);
    check("t5_instret", instret, 2);
    reg_chk("t5_r0", 0, 16'h0000);
    n_req = 0;
    repeat (20) begin
      @(negedge clk);
      #1 if (bus.imem_req || bus.dmem_req) n_req++;
    end
    check("t5_no_req", n_req, 0);

    // reset while a store waits for its ack
    clear_mem();
    imem[0] = 16'h6105; imem[1] = 16'h9103; imem[2] = 16'hF000;
    push_fetch(0); push_fetch(1);
    push_d(1, 3, 5);
    d_wait = 1000;
    start_run();
    cyc = 0;
    while (!bus.dmem_req && cyc < 50) begin
      @(negedge clk);
      #1 cyc++;
    end
    check("t6_dreq_seen", bus.dmem_req, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_dreq_drop", bus.dmem_req, 0);
    check("t6_ireq_drop", bus.imem_req, 0);
    check("t6_instret", instret, 0);
    reg_chk("t6_r1", 1, 16'h0000);
    fq.delete(); dq.delete();
    for (int i = 0; i < 3; i++) push_fetch(i);
    push_d(1, 3, 5);
    d_wait = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    force_dack = 1'b1;
    @(posedge clk);
    #1 force_dack = 1'b0;
    run_halt(cyc);
    check("t6_instret_end", instret, 3);
    check("t6_mem3", dmem[3], 16'h0005);
    check("t6_dq_empty", dq.size(), 0);

    // same with the 32-bit core
    @(posedge clk);
    #1 rst32_n = 1'b1;
    cyc = 0;
    while (!b32.dmem_req && cyc < 50) begin
      @(negedge clk);
      #1 cyc++;
    end
    check("w32_dreq_seen", b32.dmem_req, 1);
    check("w32_wdata", b32.dmem_wdata, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk);
    #2 rst32_n = 1'b0;
    #1;
    check("w32_dreq_drop", b32.dmem_req, 0);
    check("w32_instret", ir32, 0);
    dbg32_a = 1;
    #1 check("w32_r1", dbg32_d, 0);
    @(posedge clk);
    #1 rst32_n = 1'b1;
    d32_late = 1'b1;
    @(posedge clk);
    #1 d32_late = 1'b0;
    d32_ok = 1'b1;
    cyc = 0;
    while (!h32 && cyc < 100) begin
      @(negedge clk);
      #1 cyc++;
    end
    check("w32_halted", h32, 1);
    check("w32_instret_end", ir32, 3);
    check("w32_stores", n_st32, 1);
    check("w32_pc", b32.imem_addr, 2);
    check("w32_r1_end", dbg32_d, 32'hFFFF_FFFE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
- Parametrised multi-cycle successor to the 16-bit pipelined core.
- Same 16-bit instruction format: opcode[15:12], rd[11:8], rs[7:4], rt[3:0]. 16 registers.
- Data width and PC width are generalised.
- Fetch and data accesses use req/ack handshakes, so variable-latency memories are tolerated; the pipelined core needed zero-wait arrays.
- Adds an illegal-opcode trap and a retired-instruction counter. Sits as the core between instruction memory, data memory and the test harness.

Parameters:
- DATA_WIDTH, 16, register/ALU/data-bus width; must be ≥16.
- PC_WIDTH, 16, instruction address width; must be ≤DATA_WIDTH.
- CNT_WIDTH, 32, retired-instruction counter width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  fetch address; equals PC.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DATA_WIDTH  data address.
- dmem_wdata  out  DATA_WIDTH  store data.
- dmem_ack  in  1  access complete; load data valid.
- dmem_rdata  in  DATA_WIDTH  load data.
- debug_addr  in  4  register select.
- debug_data  out  DATA_WIDTH  combinational read of the selected register (r0 reads 0).
- halted  out  1  core stopped.
- illegal  out  1  stopped on an illegal opcode.
- instret  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_PC; all registers 0; instret 0; state FETCH.
  - imem_req, dmem_req, halted and illegal are 0 while reset is low.
  - A transaction in flight is abandoned; ack arriving after reset is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On imem_ack: IR<=imem_rdata, go to DECODE.
- DECODE: latch A=R[rs] (JR/ST/BEQZ/ADDI use R[rd] as noted), B=R[rt], sign-extended immediates. Go to EXEC.
- EXEC: compute result, next PC or address. Next state is MEM (LD/ST), WB (register writers), FETCH (branch, jump, JR), or HALT.
- MEM:
  - dmem_req=1; addr, we and wdata held stable until dmem_ack.
  - Load data is captured on ack. Then go to WB (LD) or FETCH (ST).
- WB: write register, then go to FETCH.
- Retirement: PC update and instret+1 occur on the cycle leaving WB, MEM (ST) or EXEC (control flow).
- Zero-wait latency (ack in the same cycle as req):
  - ALU/LDI/ADDI/JAL: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - BEQZ/JMP/JR: 3 cycles.
  - Each wait cycle on ack adds 1.
- ack without req is ignored. req never drops before ack except on reset.
- ISA:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR: rd = rs op rt.
  - 0101 SLT: rd = (signed rs < rt) ? 1 : 0.
  - 0110 LDI: rd = sext(IR[7:0]).
  - 0111 ADDI: rd = rd + sext(IR[7:0]).
  - 1000 LD: rd = M[rs + sext(IR[3:0])].
  - 1001 ST: M[rs + sext(IR[3:0])] = rd.
  - 1010 BEQZ: if rd==0 then PC = PC+1+sext(IR[7:0]), else PC+1.
  - 1011 JMP: PC = zext(IR[11:0]).
  - 1100 JAL: rd = PC+1; PC = zext(IR[7:0]).
  - 1101 JR: PC = R[rd][PC_WIDTH-1:0].
  - 1110: illegal.
  - 1111: HALT.
- Arithmetic:
  - Results are modulo 2^DATA_WIDTH; PC arithmetic is modulo 2^PC_WIDTH (PC 0xFFFF+1 wraps to 0).
  - JAL link is zero-extended to DATA_WIDTH.
- r0 is hardwired to 0; all writes to it are discarded, including JAL with rd=0 and LD with rd=0. The load bus cycle still occurs.
- HALT:
  - Sets halted=1; PC is not advanced; the halt instruction counts as retired.
  - No further requests; state is held until reset.
- Illegal (1110): halted=1, illegal=1, PC left at the offending instruction, instret not incremented.
- instret wraps silently at 2^CNT_WIDTH.

Decomposition:
- Package cpu_mc_pkg:
  - opcode localparams (OP_ADD..OP_HALT);
  - state encoding (ST_FETCH..ST_HALT);
  - ALU op codes.
- One sub-module, cpu_mc_alu: combinational, DATA_WIDTH-parametrised, ops ADD/SUB/AND/OR/XOR/SLT/PASS_B.
- Register array, FSM, PC and counter stay in cpu_mc.

Test Plan:
1. Zero-wait memory. Program LDI r1,5; LDI r2,-3; ADD r3,r1,r2; HALT → r3=2, halted after 4+4+4+3=15 cycles, instret=4.
2. imem_ack delayed 3 cycles on every fetch of the same program → imem_addr stable while req is high, total 27 cycles, results unchanged.
3. Stores and loads. ST r1 to [r4+2] with r4=0x10, r1=0xBEEF, then LD r5,[r4+2] → dmem_addr=0x12, dmem_we=1 then 0, r5=0xBEEF.
4. Control flow.
   - BEQZ r0,+2 skips two instructions.
   - JAL r7,0x40 gives r7 = old PC+1 and PC=0x40.
   - JR r7 returns to the link address.
   - PC 0xFFFF with a non-jump instruction wraps PC to 0x0000.
5. Opcode 1110 at PC 0x08 → halted=1, illegal=1, PC=0x08, no further imem_req; LDI r0,7 leaves debug_data(r0)=0.
6. Reset mid-operation. Drop reset low while dmem_req=1 and ack has not yet arrived → req=0 immediately, registers and instret cleared; a late dmem_ack after release is ignored; fetch restarts at RESET_PC; repeat with DATA_WIDTH=32.
